rp_8bit_asm_enc: RTL and testbench

Hardware instruction encoder for the rp_8bit core, the inverse of the disassembler. It accepts structured instruction requests (mnemonic code plus operands) over a valid/ready handshake. It emits the corresponding 16-bit AVR opcode words, each paired with an incrementing program address, over a second valid/ready handshake. It sits between bench or boot-loader sequencers and the program memory write port, so instruction streams can be built without precomputed hex images.

---
 rtl/rp_8bit_asm_enc.sv | 167 ++++++++++++++++
 tb/tb_rp_8bit_asm_enc.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rp_8bit_asm_enc.sv
// rp_8bit instruction encoder: structured requests in, 16-bit AVR opcode words with program addresses out.
// Optional RP_8BIT_ASM_LONG_EN enables the two-word JMP/CALL/LDS/STS encodings.
module rp_8bit_asm_enc #(
    parameter logic [15:0] ADR_RST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rr,
    input  logic [21:0] in_k,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [15:0] out_adr,
    output logic [15:0] out_dat,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE
`ifdef RP_8BIT_ASM_LONG_EN
        ,
        ST_HI,
        ST_LO
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dat_q, dat_d;
    logic [15:0] adr_q, adr_d;
    logic        err_q, err_d;

    logic [15:0] enc_w0;
    logic        enc_ill;
    logic        enc_two;
    logic        acc, hs;

    // Group-relative sub-codes taken from the low op bits (modular offsets from each group base).
    logic [3:0] op_alu, op_imm;
    logic [2:0] op_one, one_sel;
    logic [1:0] op_fm;
    logic       rd_fm, rr_fm;

    assign op_alu  = in_op[3:0] - 4'd6;
    assign op_imm  = in_op[3:0] - 4'd15;
    assign op_one  = in_op[2:0] - 3'd1;
    assign op_fm   = in_op[1:0] - 2'd3;
    assign one_sel = (op_one < 3'd4) ? op_one : op_one + 3'd1;
    assign rd_fm   = (in_rd[4:3] == 2'b10);
    assign rr_fm   = (in_rr[4:3] == 2'b10);

    always_comb begin
        enc_w0  = 16'h0000;
        enc_ill = 1'b0;
        enc_two = 1'b0;
        case (in_op) inside
            6'd0:          enc_w0 = 16'h0000;
            6'd1: begin
                enc_w0  = {8'h01, in_rd[4:1], in_rr[4:1]};
                enc_ill = in_rd[0] | in_rr[0];
            end
            6'd2: begin
                enc_w0  = {8'h02, in_rd[3:0], in_rr[3:0]};
                enc_ill = !(in_rd[4] && in_rr[4]);
            end
            [6'd3:6'd6]: begin
                enc_w0  = {8'h03, op_fm[1], in_rd[2:0], op_fm[0], in_rr[2:0]};
                enc_ill = !(rd_fm && rr_fm);
            end
            [6'd7:6'd17]:  enc_w0 = {2'b00, op_alu, in_rr[4], in_rd, in_rr[3:0]};
            [6'd18:6'd22]: begin
                enc_w0  = {op_imm, in_k[7:4], in_rd[3:0], in_k[3:0]};
                enc_ill = !in_rd[4];
            end
            // LDD (odd code) loads, STD (even code) stores; rr[0] picks Y over Z.
            6'd23, 6'd24:  enc_w0 = {2'b10, in_k[5], 1'b0, in_k[4:3], ~in_op[0], in_rd, in_rr[0], in_k[2:0]};
            [6'd25:6'd31]: enc_w0 = {7'b1001010, in_rd, 1'b0, one_sel};
            6'd32:         enc_w0 = {6'b100111, in_rr[4], in_rd, in_rr[3:0]};
`ifdef RP_8BIT_ASM_LONG_EN
            6'd33, 6'd34: begin
                enc_w0  = {7'b1001010, in_k[21:17], 2'b11, ~in_op[0], in_k[16]};
                enc_two = 1'b1;
            end
            6'd35, 6'd36: begin
                enc_w0  = {6'b100100, ~in_op[0], in_rd, 4'b0000};
                enc_two = 1'b1;
            end
`endif
            default:       enc_ill = 1'b1;
        endcase
    end

    assign out_vld = (state_q != ST_EMPTY);
    assign hs      = out_vld && out_rdy;
    assign acc     = in_vld && in_rdy;
`ifdef RP_8BIT_ASM_LONG_EN
    assign in_rdy  = (state_q != ST_HI) && (!out_vld || out_rdy);
`else
    assign in_rdy  = !out_vld || out_rdy;
`endif

`ifdef RP_8BIT_ASM_LONG_EN
    logic [15:0] lo_q, lo_d;
`else
    logic unused_k;
    assign unused_k = ^in_k[21:8] ^ enc_two;
`endif

    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        adr_d   = adr_q;
        err_d   = acc && enc_ill;
`ifdef RP_8BIT_ASM_LONG_EN
        lo_d    = lo_q;
`endif
        if (hs) begin
            adr_d   = adr_q + 16'd1;
            state_d = ST_EMPTY;
        end
`ifdef RP_8BIT_ASM_LONG_EN
        if (hs && state_q == ST_HI) begin
            state_d = ST_LO;
            dat_d   = lo_q;
        end
`endif
        // Accept never coincides with HI, so a new word cannot collide with a pending second word.
        if (acc && !enc_ill) begin
            dat_d   = enc_w0;
            state_d = ST_ONE;
`ifdef RP_8BIT_ASM_LONG_EN
            if (enc_two) begin
                state_d = ST_HI;
                lo_d    = in_k[15:0];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            dat_q   <= 16'h0000;
            adr_q   <= ADR_RST;
            err_q   <= 1'b0;
`ifdef RP_8BIT_ASM_LONG_EN
            lo_q    <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            adr_q   <= adr_d;
            err_q   <= err_d;
`ifdef RP_8BIT_ASM_LONG_EN
            lo_q    <= lo_d;
`endif
        end
    end

    assign out_dat = dat_q;
    assign out_adr = adr_q;
    assign err     = err_q;

endmodule

// File: tb/tb_rp_8bit_asm_enc.sv
// Testbench for rp_8bit_asm_enc: constant vector table, stall/reset/wrap sequences and
// randomized requests checked against a queue-based reference model.
module tb_rp_8bit_asm_enc;

    logic        clk;
    logic        rst_n;
    logic        in_vld, in_rdy;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_rr;
    logic [21:0] in_k;
    logic        out_vld, out_rdy;
    logic [15:0] out_adr, out_dat;
    logic        err;

    logic        w_in_vld, w_in_rdy;
    logic [5:0]  w_in_op;
    logic [4:0]  w_in_rd, w_in_rr;
    logic [21:0] w_in_k;
    logic        w_out_vld, w_out_rdy;
    logic [15:0] w_out_adr, w_out_dat;
    logic        w_err;

    rp_8bit_asm_enc u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_op(in_op), .in_rd(in_rd), .in_rr(in_rr), .in_k(in_k),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_adr(out_adr), .out_dat(out_dat), .err(err)
    );

    rp_8bit_asm_enc #(.ADR_RST(16'hFFFF)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .in_vld(w_in_vld), .in_rdy(w_in_rdy), .in_op(w_in_op), .in_rd(w_in_rd), .in_rr(w_in_rr), .in_k(w_in_k),
        .out_vld(w_out_vld), .out_rdy(w_out_rdy), .out_adr(w_out_adr), .out_dat(w_out_dat), .err(w_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: words awaiting output, next address, pending err pulse.
    logic [15:0] mq[$];
    logic [15:0] adr_m;
    bit          err_pend;

    bit          cur_ill, cur_two;
    logic [15:0] cur_w0, cur_w1;
    bit          rnd_rdy;

    typedef struct {
        int          op;
        int          rd;
        int          rr;
        int          k;
        bit          ill;
        logic [15:0] w0;
        logic [15:0] w1;
        bit          two;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding rules from the AVR layouts, computed with plain integer field arithmetic.
    function automatic void ref_enc(input int op, input int rd, input int rr, input int k,
                                    output bit ill, output logic [15:0] w0, output logic [15:0] w1,
                                    output bit two);
        int v;
        int kk;
        int kb;
        kk  = k % 4194304;
        kb  = kk % 256;
        ill = 1'b0;
        two = 1'b0;
        v   = 0;
        w1  = 16'h0000;
        if (op == 0) v = 0;
        else if (op == 1) begin
            ill = (rd % 2 != 0) || (rr % 2 != 0);
            v = 256 + (rd / 2) * 16 + rr / 2;
        end else if (op == 2) begin
            ill = (rd < 16) || (rr < 16);
            v = 512 + (rd % 16) * 16 + rr % 16;
        end else if (op >= 3 && op <= 6) begin
            ill = !(rd >= 16 && rd <= 23 && rr >= 16 && rr <= 23);
            v = 768 + ((op - 3) / 2) * 128 + (rd % 8) * 16 + ((op - 3) % 2) * 8 + rr % 8;
        end else if (op >= 7 && op <= 17) begin
            v = (op - 6) * 1024 + (rr / 16) * 512 + rd * 16 + rr % 16;
        end else if (op >= 18 && op <= 22) begin
            ill = rd < 16;
            v = (op - 15) * 4096 + (kb / 16) * 256 + (rd % 16) * 16 + kb % 16;
        end else if (op == 23 || op == 24) begin
            v = 32768 + ((kk % 64) / 32) * 8192 + ((kk % 32) / 8) * 1024 + (op - 23) * 512
                + rd * 16 + (rr % 2) * 8 + kk % 8;
        end else if (op >= 25 && op <= 31) begin
            v = 37888 + rd * 16 + ((op - 25 >= 4) ? op - 24 : op - 25);
        end else if (op == 32) begin
            v = 39936 + (rr / 16) * 512 + rd * 16 + rr % 16;
`ifdef RP_8BIT_ASM_LONG_EN
        end else if (op == 33 || op == 34) begin
            two = 1'b1;
            v = 37900 + (op - 33) * 2 + (kk / 131072) * 16 + (kk / 65536) % 2;
            w1 = 16'(kk % 65536);
        end else if (op == 35 || op == 36) begin
            two = 1'b1;
            v = 36864 + (op - 35) * 512 + rd * 16;
            w1 = 16'(kk % 65536);
`endif
        end else begin
            ill = 1'b1;
        end
        w0 = 16'(v);
    endfunction

    // One clock of checking: compare DUT outputs with the model, then advance the model.
    task automatic cycle(output bit acc);
        bit exp_vld, exp_rdy, hs;
        @(negedge clk);
        exp_vld = (mq.size() != 0);
        exp_rdy = (mq.size() < 2) && (!exp_vld || out_rdy);
        chk("in_rdy", 16'(in_rdy), 16'(exp_rdy));
        chk("out_vld", 16'(out_vld), 16'(exp_vld));
        chk("out_adr", out_adr, adr_m);
        if (exp_vld) chk("out_dat", out_dat, mq[0]);
        chk("err", 16'(err), 16'(err_pend));
        hs  = exp_vld && out_rdy;
        acc = in_vld && exp_rdy;
        if (hs) begin
            void'(mq.pop_front());
            adr_m = adr_m + 16'd1;
        end
        err_pend = 1'b0;
        if (acc) begin
            if (cur_ill) err_pend = 1'b1;
            else begin
                mq.push_back(cur_w0);
                if (cur_two) mq.push_back(cur_w1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int op, input int rd, input int rr, input int k,
                             input bit ill, input logic [15:0] w0, input logic [15:0] w1, input bit two);
        bit acc;
        int n;
        in_op = 6'(op); in_rd = 5'(rd); in_rr = 5'(rr); in_k = 22'(k);
        in_vld = 1'b1;
        cur_ill = ill; cur_w0 = w0; cur_w1 = w1; cur_two = two;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            if (rnd_rdy) out_rdy = ($urandom_range(0, 3) != 0);
            cycle(acc);
            n++;
        end
        in_vld = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: op=%0d not accepted within 50 cycles", op);
        end else begin
            $display("req op=%0d rd=%0d rr=%0d k=%h -> ill=%0d w0=%h w1=%h two=%0d",
                     op, rd, rr, k, ill, w0, w1, two);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        in_vld = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (rnd_rdy) out_rdy = ($urandom_range(0, 3) != 0);
            cycle(acc);
        end
    endtask

    task automatic send_ref(input int op, input int rd, input int rr, input int k);
        bit ill, two;
        logic [15:0] w0, w1;
        ref_enc(op, rd, rr, k, ill, w0, w1, two);
        drive_req(op, rd, rr, k, ill, w0, w1, two);
    endtask

    initial begin
        tbl[0]  = '{9, 1, 2, 0, 1'b0, 16'h0C12, 16'h0000, 1'b0};          // ADD r1,r2
        tbl[1]  = '{20, 16, 0, 32'h55, 1'b0, 16'h5505, 16'h0000, 1'b0};   // SUBI r16,0x55
        tbl[2]  = '{20, 15, 0, 32'h55, 1'b1, 16'h0000, 16'h0000, 1'b0};   // SUBI r15 illegal
        tbl[3]  = '{1, 3, 4, 0, 1'b1, 16'h0000, 16'h0000, 1'b0};          // MOVW odd rd
        tbl[4]  = '{1, 2, 4, 0, 1'b0, 16'h0112, 16'h0000, 1'b0};          // MOVW r2,r4
        tbl[5]  = '{23, 5, 1, 32'h3F, 1'b0, 16'hAC5F, 16'h0000, 1'b0};    // LDD r5,Y+63
        tbl[6]  = '{24, 5, 0, 0, 1'b0, 16'h8250, 16'h0000, 1'b0};         // STD Z+0,r5
`ifdef RP_8BIT_ASM_LONG_EN
        tbl[7]  = '{33, 0, 0, 32'h001234, 1'b0, 16'h940C, 16'h1234, 1'b1};
        tbl[8]  = '{34, 0, 0, 32'h3F1234, 1'b0, 16'h95FF, 16'h1234, 1'b1};
        tbl[9]  = '{35, 17, 0, 32'h3FABCD, 1'b0, 16'h9110, 16'hABCD, 1'b1};
`else
        tbl[7]  = '{33, 0, 0, 32'h001234, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tbl[8]  = '{34, 0, 0, 32'h3F1234, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tbl[9]  = '{35, 17, 0, 32'h3FABCD, 1'b1, 16'h0000, 16'h0000, 1'b0};
`endif
        tbl[10] = '{40, 0, 0, 0, 1'b1, 16'h0000, 16'h0000, 1'b0};         // undefined code
        tbl[11] = '{2, 17, 31, 0, 1'b0, 16'h021F, 16'h0000, 1'b0};        // MULS r17,r31
        tbl[12] = '{6, 23, 16, 0, 1'b0, 16'h03F8, 16'h0000, 1'b0};        // FMULSU r23,r16
        tbl[13] = '{31, 31, 0, 0, 1'b0, 16'h95F7, 16'h0000, 1'b0};        // ROR r31
        tbl[14] = '{32, 31, 31, 0, 1'b0, 16'h9FFF, 16'h0000, 1'b0};       // MUL r31,r31
        tbl[15] = '{18, 31, 0, 32'h1FF, 1'b0, 16'h3FFF, 16'h0000, 1'b0};  // CPI r31,0xFF (k truncated)
        tbl[16] = '{3, 24, 16, 0, 1'b1, 16'h0000, 16'h0000, 1'b0};        // MULSU r24 out of range

        in_vld = 1'b0; in_op = '0; in_rd = '0; in_rr = '0; in_k = '0; out_rdy = 1'b1;
        w_in_vld = 1'b0; w_in_op = '0; w_in_rd = '0; w_in_rr = '0; w_in_k = '0; w_out_rdy = 1'b1;
        rnd_rdy = 1'b0;
        adr_m = 16'h0000;
        err_pend = 1'b0;
        cur_ill = 1'b0; cur_two = 1'b0; cur_w0 = '0; cur_w1 = '0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_vld", 16'(out_vld), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_out_dat", out_dat, 16'h0000);
        chk("rst_out_adr", out_adr, 16'h0000);
        chk("rst_in_rdy", 16'(in_rdy), 16'h1);
        chk("rst_wrap_adr", w_out_adr, 16'hFFFF);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Address wrap on the second instance: two NOPs at 0xFFFF then 0x0000.
        w_in_vld = 1'b1;
        @(posedge clk); #1;
        chk("wrap_vld0", 16'(w_out_vld), 16'h1);
        chk("wrap_adr0", w_out_adr, 16'hFFFF);
        chk("wrap_dat0", w_out_dat, 16'h0000);
        @(posedge clk); #1;
        w_in_vld = 1'b0;
        chk("wrap_vld1", 16'(w_out_vld), 16'h1);
        chk("wrap_adr1", w_out_adr, 16'h0000);
        @(posedge clk); #1;
        chk("wrap_empty", 16'(w_out_vld), 16'h0);
        chk("wrap_err", 16'(w_err), 16'h0);
        $display("wrap: NOP pair issued at 0xFFFF/0x0000");

        foreach (tbl[i])
            drive_req(tbl[i].op, tbl[i].rd, tbl[i].rr, tbl[i].k,
                      tbl[i].ill, tbl[i].w0, tbl[i].w1, tbl[i].two);
        idle(3);

        // Output held under back-pressure: single-word then JMP pair.
        out_rdy = 1'b0;
        send_ref(9, 1, 2, 0);
        idle(3);
        out_rdy = 1'b1;
        idle(2);
        out_rdy = 1'b0;
        send_ref(33, 0, 0, 32'h001234);
        idle(3);
        out_rdy = 1'b1;
        idle(3);

        // Asynchronous reset while a word (or pair) is pending.
        out_rdy = 1'b0;
        send_ref(33, 0, 0, 32'h00ABCD);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_vld", 16'(out_vld), 16'h0);
        chk("midrst_out_adr", out_adr, 16'h0000);
        chk("midrst_in_rdy", 16'(in_rdy), 16'h1);
        $display("reset asserted with pending output");
        @(negedge clk) rst_n = 1'b1;
        mq.delete();
        adr_m = 16'h0000;
        err_pend = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        idle(2);

        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_ref($urandom_range(0, 40), $urandom_range(0, 31), $urandom_range(0, 31),
                     int'($urandom_range(0, 32'h3FFFFF)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_rdy = 1'b0;
        out_rdy = 1'b1;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
